// File: rtl/ama_riscv_mem_arbiter_pkg.sv
//==============================================================================
// Module   : ama_riscv_mem_arbiter_pkg
// Brief    : Shared types and widths for the IF/LS memory arbiter
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package ama_riscv_mem_arbiter_pkg;

  localparam int unsigned CORE_ADDR_BUS_W = 14;
  localparam int unsigned CORE_DATA_BUS   = 32;

  // Tag stored per outstanding read; tells the response demux who asked
  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_src_e;

  // Backend request fields at the core's native widths
  typedef struct packed {
    logic                         we;
    logic [CORE_ADDR_BUS_W-1:0]   addr;
    logic [CORE_DATA_BUS-1:0]     wdata;
    logic [CORE_DATA_BUS/8-1:0]   wstrb;
  } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/ama_riscv_tag_fifo.sv
//==============================================================================
// Module   : ama_riscv_tag_fifo
// Brief    : Small in-order FIFO of 1-bit requester tags. A pop in the same
//            cycle frees a slot, so push+pop while full is accepted.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ama_riscv_tag_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic pop_data,
  output logic full,
  output logic empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_pop;
  logic             do_push;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr];

  // Pointer advance with wrap at DEPTH (depth need not be a power of two)
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr] <= push_data;
        wr_ptr        <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ama_riscv_mem_arbiter.sv
//==============================================================================
// Module   : ama_riscv_mem_arbiter
// Brief    : Round-robin arbiter sharing one memory backend between
//            instruction fetch and load/store; routes in-order read
//            responses back to their requester with zero added latency.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ama_riscv_mem_arbiter
  import ama_riscv_mem_arbiter_pkg::*;
#(
  parameter int unsigned AW      = CORE_ADDR_BUS_W,
  parameter int unsigned DW      = CORE_DATA_BUS,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  // instruction fetch
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [AW-1:0]   if_req_addr,
  output logic            if_rsp_valid,
  output logic [DW-1:0]   if_rsp_data,
  // load/store
  input  logic            ls_req_valid,
  output logic            ls_req_ready,
  input  logic            ls_req_we,
  input  logic [AW-1:0]   ls_req_addr,
  input  logic [DW-1:0]   ls_req_wdata,
  input  logic [DW/8-1:0] ls_req_wstrb,
  output logic            ls_rsp_valid,
  output logic [DW-1:0]   ls_rsp_data,
  // memory backend
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_we,
  output logic [AW-1:0]   mem_req_addr,
  output logic [DW-1:0]   mem_req_wdata,
  output logic [DW/8-1:0] mem_req_wstrb,
  input  logic            mem_rsp_valid,
  input  logic [DW-1:0]   mem_rsp_data,
  // status
  output logic            err_unexp_rsp
);

  typedef struct packed {
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
  } req_t;

  req_src_e rr_last;
  req_src_e head_src;
  req_t     req_mux;
  logic     fifo_full;
  logic     fifo_empty;
  logic     fifo_head;
  logic     rsp_pop;
  logic     fifo_full_eff;
  logic     if_elig;
  logic     ls_elig;
  logic     grant_ls;
  logic     accept;
  logic     tag_push;

  // A response arriving this cycle frees its slot before any new push
  assign rsp_pop       = mem_rsp_valid && !fifo_empty;
  assign fifo_full_eff = fifo_full && !rsp_pop;

  // Writes never occupy a tag slot, so LS writes bypass the full check
  assign if_elig = if_req_valid && !fifo_full_eff;
  assign ls_elig = ls_req_valid && (ls_req_we || !fifo_full_eff);

  // Lone eligible source wins; on a tie the one not served last wins
  always_comb begin
    grant_ls = ls_elig;
    if (ls_elig && if_elig) begin
      grant_ls = (rr_last == REQ_IF);
    end
  end

  // Request field mux; IF is read-only so its write fields are zero
  always_comb begin
    req_mux      = '0;
    req_mux.addr = if_req_addr;
    if (grant_ls) begin
      req_mux.we    = ls_req_we;
      req_mux.addr  = ls_req_addr;
      req_mux.wdata = ls_req_wdata;
      req_mux.wstrb = ls_req_wstrb;
    end
  end

  assign mem_req_valid = if_elig || ls_elig;
  assign mem_req_we    = req_mux.we;
  assign mem_req_addr  = req_mux.addr;
  assign mem_req_wdata = req_mux.wdata;
  assign mem_req_wstrb = req_mux.wstrb;

  assign if_req_ready  = if_elig && !grant_ls && mem_req_ready;
  assign ls_req_ready  = grant_ls && mem_req_ready;

  assign accept        = mem_req_valid && mem_req_ready;
  assign tag_push      = accept && !req_mux.we;

  // Record who got the last accepted beat for round-robin fairness
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= REQ_IF;
    end else if (accept) begin
      rr_last <= grant_ls ? REQ_LS : REQ_IF;
    end
  end

  ama_riscv_tag_fifo #(
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tag_push),
    .push_data (grant_ls),
    .pop       (rsp_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Response demux: the oldest outstanding tag owns this response
  assign head_src     = req_src_e'(fifo_head);
  assign if_rsp_valid = rsp_pop && (head_src == REQ_IF);
  assign ls_rsp_valid = rsp_pop && (head_src == REQ_LS);
  assign if_rsp_data  = mem_rsp_data;
  assign ls_rsp_data  = mem_rsp_data;

  // Sticky flag for a backend response nobody asked for
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_unexp_rsp <= 1'b0;
    end else if (mem_rsp_valid && fifo_empty) begin
      err_unexp_rsp <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ama_riscv_mem_arbiter.sv
//==============================================================================
// Module   : tb_ama_riscv_mem_arbiter
// Brief    : Self-checking bench with cycle model and response scoreboard
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ama_riscv_mem_arbiter;

  localparam int AW      = 14;
  localparam int DW      = 32;
  localparam int MAX_OUT = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            if_req_valid = 1'b0;
  logic            if_req_ready;
  logic [AW-1:0]   if_req_addr = '0;
  logic            if_rsp_valid;
  logic [DW-1:0]   if_rsp_data;
  logic            ls_req_valid = 1'b0;
  logic            ls_req_ready;
  logic            ls_req_we = 1'b0;
  logic [AW-1:0]   ls_req_addr = '0;
  logic [DW-1:0]   ls_req_wdata = '0;
  logic [DW/8-1:0] ls_req_wstrb = '0;
  logic            ls_rsp_valid;
  logic [DW-1:0]   ls_rsp_data;
  logic            mem_req_valid;
  logic            mem_req_ready = 1'b0;
  logic            mem_req_we;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_wdata;
  logic [DW/8-1:0] mem_req_wstrb;
  logic            mem_rsp_valid = 1'b0;
  logic [DW-1:0]   mem_rsp_data = '0;
  logic            err_unexp_rsp;

  always #5 clk = ~clk;

  ama_riscv_mem_arbiter #(
    .AW (AW), .DW (DW), .MAX_OUT (MAX_OUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_req_addr   (if_req_addr),
    .if_rsp_valid  (if_rsp_valid),
    .if_rsp_data   (if_rsp_data),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_req_we     (ls_req_we),
    .ls_req_addr   (ls_req_addr),
    .ls_req_wdata  (ls_req_wdata),
    .ls_req_wstrb  (ls_req_wstrb),
    .ls_rsp_valid  (ls_rsp_valid),
    .ls_rsp_data   (ls_rsp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .err_unexp_rsp (err_unexp_rsp)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Backend memory contents: a fixed function of the word address
  function automatic logic [31:0] mem_fn(input logic [AW-1:0] a);
    return {8'hC0, a[7:0] ^ 8'h5A, 2'b00, a};
  endfunction

  // Backend: answers accepted reads in order, one per cycle, when enabled
  logic [AW-1:0] be_q[$];
  bit rsp_en     = 1'b0;
  bit inj_unexp  = 1'b0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      be_q.delete();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end else if (inj_unexp) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hDEAD_BEEF;
    end else if (rsp_en && be_q.size() > 0) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_fn(be_q.pop_front());
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
  end

  // Cycle model + scoreboard, evaluated mid-cycle when everything is settled
  bit            m_rr;          // 0 = IF served last, 1 = LS
  bit            m_tags[$];
  logic [31:0]   m_data[$];
  bit            m_err;
  int            n_if_exp = 0, n_ls_exp = 0, n_if_got = 0, n_ls_got = 0;

  always @(negedge clk) begin
    bit pop, fe, ie, le, gls, v, wexp, t;
    logic [31:0] d;
    if (!rst_n) begin
      m_rr  = 1'b0;
      m_err = 1'b0;
      m_tags.delete();
      m_data.delete();
    end else begin
      if (if_rsp_valid) n_if_got++;
      if (ls_rsp_valid) n_ls_got++;
      if (mem_req_valid && mem_req_ready && !mem_req_we) be_q.push_back(mem_req_addr);

      pop  = mem_rsp_valid && (m_tags.size() > 0);
      fe   = (m_tags.size() == MAX_OUT) && !pop;
      ie   = if_req_valid && !fe;
      le   = ls_req_valid && (ls_req_we || !fe);
      gls  = le && (!ie || !m_rr);
      v    = ie || le;
      wexp = gls && ls_req_we;

      check("mem_req_valid", mem_req_valid, v);
      check("if_req_ready", if_req_ready, ie && !gls && mem_req_ready);
      check("ls_req_ready", ls_req_ready, gls && mem_req_ready);
      if (v) begin
        check("mem_req_we", mem_req_we, wexp);
        check("mem_req_addr", mem_req_addr, gls ? ls_req_addr : if_req_addr);
        check("mem_req_wstrb", mem_req_wstrb, gls ? ls_req_wstrb : 4'h0);
        check("mem_req_wdata", mem_req_wdata, gls ? ls_req_wdata : 32'h0);
      end

      check("err_unexp_rsp", err_unexp_rsp, m_err);
      if (mem_rsp_valid && m_tags.size() == 0) m_err = 1'b1;

      if (pop) begin
        t = m_tags.pop_front();
        d = m_data.pop_front();
        check("if_rsp_valid", if_rsp_valid, !t);
        check("ls_rsp_valid", ls_rsp_valid, t);
        if (t) check("ls_rsp_data", ls_rsp_data, d);
        else   check("if_rsp_data", if_rsp_data, d);
      end else begin
        check("if_rsp_valid_idle", if_rsp_valid, 1'b0);
        check("ls_rsp_valid_idle", ls_rsp_valid, 1'b0);
      end

      if (v && mem_req_ready) begin
        m_rr = gls;
        if (!wexp) begin
          m_tags.push_back(gls);
          m_data.push_back(mem_fn(gls ? ls_req_addr : if_req_addr));
          if (gls) n_ls_exp++;
          else     n_if_exp++;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    check("rst_err", err_unexp_rsp, 1'b0);
    check("rst_mem_req_valid", mem_req_valid, 1'b0);
    check("rst_if_ready", if_req_ready, 1'b0);
    check("rst_ls_ready", ls_req_ready, 1'b0);
    check("rst_if_rsp", if_rsp_valid, 1'b0);
    check("rst_ls_rsp", ls_rsp_valid, 1'b0);

    // IF only: four back-to-back reads
    rsp_en        = 1'b1;
    mem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_req_valid = 1'b1;
      if_req_addr  = AW'(i);
      cyc(1);
    end
    if_req_valid = 1'b0;
    cyc(3);
    check("t1_if_rsp_cnt", n_if_got, 4);
    check("t1_ls_rsp_cnt", n_ls_got, 0);

    // IF + LS reads held valid: LS first, then strict alternation
    for (int i = 0; i < 8; i++) begin
      if_req_valid = 1'b1;
      if_req_addr  = AW'(16 + i);
      ls_req_valid = 1'b1;
      ls_req_we    = 1'b0;
      ls_req_addr  = AW'(32 + i);
      #1;
      check("t2_grant_ls", ls_req_ready, (i % 2) == 0);
      cyc(1);
    end
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    cyc(3);
    check("t2_if_rsp_cnt", n_if_got, 8);
    check("t2_ls_rsp_cnt", n_ls_got, 4);

    // Responses withheld: two reads fill the tag FIFO
    rsp_en       = 1'b0;
    ls_req_valid = 1'b1;
    ls_req_addr  = AW'(48);
    cyc(1);
    ls_req_valid = 1'b0;
    if_req_valid = 1'b1;
    if_req_addr  = AW'(49);
    cyc(1);
    // third read stalls, LS write still goes through
    if_req_addr  = AW'(50);
    ls_req_valid = 1'b1;
    ls_req_we    = 1'b1;
    ls_req_addr  = AW'(64);
    ls_req_wdata = 32'h1234_5678;
    ls_req_wstrb = 4'b0011;
    #1;
    check("t3_if_stall", if_req_ready, 1'b0);
    check("t3_ls_wr_ready", ls_req_ready, 1'b1);
    check("t3_wr_we", mem_req_we, 1'b1);
    check("t3_wr_wstrb", mem_req_wstrb, 4'b0011);
    cyc(1);
    ls_req_valid = 1'b0;
    ls_req_we    = 1'b0;
    ls_req_wstrb = '0;
    ls_req_wdata = '0;
    cyc(1);
    check("t3_if_still_stalled", if_req_ready, 1'b0);

    // Full FIFO: one response and the stalled IF read in the same cycle
    rsp_en = 1'b1;
    cyc(1);
    rsp_en = 1'b0;
    check("t4_rsp_to_ls", ls_rsp_valid, 1'b1);
    check("t4_if_accept", if_req_ready, 1'b1);
    cyc(1);
    if_req_addr = AW'(51);
    #1;
    check("t4_still_full", if_req_ready, 1'b0);
    if_req_valid = 1'b0;
    rsp_en       = 1'b1;
    cyc(4);
    check("t4_if_rsp_cnt", n_if_got, 10);
    check("t4_ls_rsp_cnt", n_ls_got, 5);

    // Backend not ready for five cycles with both sources requesting
    mem_req_ready = 1'b0;
    if_req_valid  = 1'b1;
    if_req_addr   = AW'(80);
    ls_req_valid  = 1'b1;
    ls_req_addr   = AW'(96);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t5_hold_valid", mem_req_valid, 1'b1);
      check("t5_hold_addr", mem_req_addr, AW'(96));
      check("t5_hold_ls_rdy", ls_req_ready, 1'b0);
      cyc(1);
    end
    mem_req_ready = 1'b1;
    #1;
    check("t5_resume_ls", ls_req_ready, 1'b1);
    cyc(1);
    ls_req_valid = 1'b0;
    #1;
    check("t5_then_if", if_req_ready, 1'b1);
    cyc(1);
    if_req_valid = 1'b0;
    cyc(4);

    // Unexpected response is sticky until async reset
    inj_unexp = 1'b1;
    cyc(1);
    inj_unexp = 1'b0;
    cyc(2);
    check("t6_err_set", err_unexp_rsp, 1'b1);
    cyc(2);
    check("t6_err_sticky", err_unexp_rsp, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_err_async_clr", err_unexp_rsp, 1'b0);
    check("t6_rst_mem_valid", mem_req_valid, 1'b0);
    check("t6_rst_if_rsp", if_rsp_valid, 1'b0);
    check("t6_rst_ls_rsp", ls_rsp_valid, 1'b0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    check("t6_err_after_rst", err_unexp_rsp, 1'b0);

    check("final_if_rsp", n_if_got, n_if_exp);
    check("final_ls_rsp", n_ls_got, n_ls_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
